// File: rtl/alu_exec_pkg.sv
// Shared ALU definitions: funct3/funct7 fields, ALU op encodings, FSM states.
// No logic and no latency; other blocks import this package.
// Backpressure: not applicable. ALU op = {funct7[5], funct3}, as in RV32I.
package alu_exec_pkg;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [3:0] ALU_ADD  = {F7_BASE[5], F3_ADD_SUB};
   localparam logic [3:0] ALU_SUB  = {F7_ALT[5],  F3_ADD_SUB};
   localparam logic [3:0] ALU_SLL  = {F7_BASE[5], F3_SLL};
   localparam logic [3:0] ALU_SLT  = {F7_BASE[5], F3_SLT};
   localparam logic [3:0] ALU_SLTU = {F7_BASE[5], F3_SLTU};
   localparam logic [3:0] ALU_XOR  = {F7_BASE[5], F3_XOR};
   localparam logic [3:0] ALU_SRL  = {F7_BASE[5], F3_SRL_SRA};
   localparam logic [3:0] ALU_SRA  = {F7_ALT[5],  F3_SRL_SRA};
   localparam logic [3:0] ALU_OR   = {F7_BASE[5], F3_OR};
   localparam logic [3:0] ALU_AND  = {F7_BASE[5], F3_AND};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift_op(input logic [3:0] code);
      return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU: ADD, SUB, SLT, SLTU, XOR, OR, AND. Shift ops and undefined codes give 0.
// Latency: purely combinational. Backpressure: none.
// Ports: op (ALU op code), a/b (operands), y (result).
module alu_comb
   import alu_exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] y
);

   always_comb begin
      y = '0;
      unique case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_XOR:  y = a ^ b;
         ALU_OR:   y = a | b;
         ALU_AND:  y = a & b;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU. Shifts run one bit per cycle; all other ops finish in a single cycle.
// Latency: 1 cycle, or n+1 cycles for a shift by n >= 1. Requests are taken only in IDLE.
// Backpressure: start is ignored while busy. Ports: clk, rst, start, op, a, b -> busy, done, result, zero.
module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

   state_e            state_q, state_d;
   logic [3:0]        op_q;
   logic [XLEN-1:0]   work_q;
   logic [SHW-1:0]    cnt_q;
   logic [XLEN-1:0]   comb_y;
   logic [XLEN-1:0]   single_y;
   logic [XLEN-1:0]   work_step;
   logic [SHW-1:0]    shamt;
   logic              accept;
   logic              to_shift;

   alu_comb #(.XLEN(XLEN)) u_alu_comb (
      .op (op),
      .a  (a),
      .b  (b),
      .y  (comb_y)
   );

   assign shamt    = b[SHW-1:0];
   assign accept   = (state_q == ST_IDLE) && start;
   assign to_shift = accept && is_shift_op(op) && (shamt != '0);
   // A shift by zero is just a pass-through of a.
   assign single_y = is_shift_op(op) ? a : comb_y;

   // The MSB of the working register stays at the original a[XLEN-1]
   // during SRA, so replicating it gives the correct fill on every step.
   always_comb begin
      work_step = {1'b0, work_q[XLEN-1:1]};
      if (op_q == ALU_SLL) begin
         work_step = {work_q[XLEN-2:0], 1'b0};
      end else if (op_q == ALU_SRA) begin
         work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept) state_d = to_shift ? ST_SHIFT : ST_DONE;
         ST_SHIFT: if (cnt_q == CNT_ONE) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= '0;
         work_q <= '0;
         cnt_q  <= '0;
         result <= '0;
         zero   <= 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q   <= op;
                  work_q <= a;
                  cnt_q  <= shamt;
                  if (!to_shift) begin
                     result <= single_y;
                     zero   <= (single_y == '0);
                  end
               end
            end
            ST_SHIFT: begin
               work_q <= work_step;
               cnt_q  <= cnt_q - CNT_ONE;
               // Last step: counter reaches 0 on this edge.
               if (cnt_q == CNT_ONE) begin
                  result <= work_step;
                  zero   <= (work_step == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected result/zero/latency are queued when a
// request is driven and compared when done pulses. Also checks busy length,
// done pulse width, reset values, issue interval and ignored start.
module tb_alu_exec;
   import alu_exec_pkg::*;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
      string       tag;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   busy_run = 0;
   logic done_prev = 1'b0;

   alu_exec #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [4:0] sh;
      sh = y[4:0];
      case (o)
         ALU_ADD:  return x + y;
         ALU_SUB:  return x - y;
         ALU_SLL:  return x << sh;
         ALU_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (x < y) ? 32'd1 : 32'd0;
         ALU_XOR:  return x ^ y;
         ALU_SRL:  return x >> sh;
         ALU_SRA:  return $unsigned($signed(x) >>> sh);
         ALU_OR:   return x | y;
         ALU_AND:  return x & y;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic int model_lat(input logic [3:0] o, input logic [31:0] y);
      if ((o == ALU_SLL || o == ALU_SRL || o == ALU_SRA) && y[4:0] != 5'd0)
         return int'(y[4:0]) + 1;
      return 1;
   endfunction

   function automatic exp_t mk(input string t, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      e.res = model(o, x, y);
      e.lat = model_lat(o, y);
      e.acc = cyc;
      e.tag = t;
      return e;
   endfunction

   // Monitor: every output is sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_run  = 0;
            done_prev = 1'b0;
         end else begin
            if (busy) busy_run++;
            if (done) begin
               check("done_width", {31'd0, done_prev}, 32'd0);
               if (sb.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check({e.tag, "_result"}, result, e.res);
                  check({e.tag, "_zero"}, {31'd0, zero}, {31'd0, (e.res == 32'd0)});
                  check({e.tag, "_latency"}, cyc - e.acc, e.lat);
                  check({e.tag, "_busy_len"}, busy_run, e.lat);
               end
               busy_run = 0;
            end
            done_prev = done;
         end
      end
   end

   task automatic issue(input string t, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      int n;
      @(negedge clk);
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      sb.push_back(mk(t, o, x, y));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", sb.size(), 32'd0);
   endtask

   initial begin
      int last;
      rst = 1'b1;
      start = 1'b0;
      op = '0;
      a = '0;
      b = '0;
      #1;
      check("reset_result", result, 32'd0);
      check("reset_zero", {31'd0, zero}, 32'd1);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      issue("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1);
      issue("sub_zero", ALU_SUB, 32'd5, 32'd5);
      issue("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1);
      issue("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
      issue("sra31", ALU_SRA, 32'h8000_0000, 32'd31);
      issue("srl31", ALU_SRL, 32'h8000_0000, 32'd31);
      issue("sll_sh0", ALU_SLL, 32'h1, 32'h20);
      issue("xor", ALU_XOR, 32'hA5A5_0F0F, 32'hFFFF_00FF);
      issue("or", ALU_OR, 32'h1200_0034, 32'h0056_7800);
      issue("and", ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      issue("undef_op", 4'b1111, 32'h1234_5678, 32'd5);
      issue("sll4", ALU_SLL, 32'h8000_0001, 32'd4);
      issue("sra_pos", ALU_SRA, 32'h4000_0000, 32'd3);
      drain();

      // Start pulsed mid-shift with different op/operands must be ignored.
      issue("srl_ign", ALU_SRL, 32'hF000_0000, 32'd8);
      repeat (3) @(negedge clk);
      op = ALU_ADD;
      a = 32'd1;
      b = 32'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      check("ignored_hold", result, 32'h00F0_0000);

      // Reset in the 4th shift cycle: no done, outputs back to reset values.
      issue("sll_rst", ALU_SLL, 32'h1, 32'd10);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      #1;
      check("midrst_result", result, 32'd0);
      check("midrst_zero", {31'd0, zero}, 32'd1);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("postrst_busy", {31'd0, busy}, 32'd0);
      check("postrst_result", result, 32'd0);
      issue("add_after_rst", ALU_ADD, 32'd2, 32'd3);
      drain();

      // Start held high: one accept every 2 cycles.
      last = -1;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         op = (i % 3 == 0) ? ALU_ADD : ((i % 3 == 1) ? ALU_XOR : ALU_SUB);
         a = $urandom;
         b = $urandom;
         if (!busy) begin
            sb.push_back(mk("b2b", op, a, b));
            if (last >= 0) check("b2b_interval", cyc - last, 32'd2);
            last = cyc;
         end
      end
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
